led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
Generates eight 8-bit brightness levels for a "scanner" LED effect: one bright dot that bounces or wraps, followed by a fading tail. Sits directly upstream of the LED PWM generator and drives its eight per-LED data inputs. Takes that generator's frame clock back as an input. Levels change only at PWM frame boundaries, so no frame ever mixes old and new values.

Parameters:
STEP_FRAMES, 4, PWM frames per scanner step; legal range 1..256.
DECAY_SHIFT, 1, right-shift applied to every level on each step; legal range 0..8 (0 = no decay, 8 = instant off).
PEAK, 8'hFF, level loaded into the LED at the dot position.

Ports:
clk  input  1  system clock (same clock that drives the PWM stage)
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run; 0 = freeze all state and outputs
fclk  input  1  frame clock from the PWM stage; rising edge marks a frame boundary
mode  input  1  0 = bounce scan, 1 = wrap scan (upward only)
led1..led8  output  8 each  brightness levels, registered; led1 = position 0, led8 = position 7
pos  output  3  current dot position, registered
step_strobe  output  1  one-cycle pulse, high in the same cycle that a step update becomes visible on the outputs

Behaviour:
- One clock domain: clk. reset is synchronous and active-high and overrides every other input in the cycle it is sampled, including a coincident frame tick.
- Reset values: led1 = PEAK; led2..led8 = 0; pos = 0; direction state = UP; frame counter = 0; fclk_d = 0; step_strobe = 0.
- Edge detect: fclk_d registers fclk each cycle. frame_tick = fclk & ~fclk_d, one cycle wide.
  - fclk held high for any number of cycles counts as exactly one tick.
  - fclk already high at reset release produces one tick in the first cycle after reset.
- Frame counter (8 bits) advances only on frame_tick with enable = 1.
  - If counter == STEP_FRAMES-1: counter goes to 0 and a step occurs.
  - Otherwise: counter + 1.
  - STEP_FRAMES = 1 steps on every tick.
- enable = 0: ticks are ignored. Counter, pos, direction and levels all hold. fclk_d keeps tracking fclk, so re-enabling while fclk is high does not create a tick.
- Step (registered; outputs update on the clock edge that samples frame_tick, i.e. 1-cycle latency from the tick):
  - Every led_i takes led_i >> DECAY_SHIFT (logical shift).
  - The LED at the new pos is then loaded with PEAK, overriding its decayed value.
  - step_strobe = 1 for exactly that one cycle; 0 otherwise.
- Direction FSM, states UP and DOWN, evaluated at each step:
  - mode = 0, UP: pos < 7 -> pos + 1, stay UP; pos = 7 -> pos = 6, go to DOWN.
  - mode = 0, DOWN: pos > 0 -> pos - 1, stay DOWN; pos = 0 -> pos = 1, go to UP.
  - mode = 1: pos = (pos + 1) mod 8; state forced to UP regardless of its previous value.
  - mode is sampled only at a step; a change takes effect at the next step.
- Width rules:
  - Levels are unsigned 8-bit values.
  - A shift of 8 yields 0.
  - pos arithmetic is 3-bit; wrap 7 -> 0 applies only in mode 1.
- Non-step ticks and idle cycles: outputs hold their values; step_strobe = 0.

Test Plan:
1. Reset with fclk low -> led1 = FF, led2..led8 = 00, pos = 0, step_strobe = 0. Hold enable = 1 for 20 cycles with no fclk edges -> all outputs unchanged.
2. Defaults, mode = 0, apply 4 fclk pulses (high 3 cycles, low 5 cycles) -> no change after pulses 1-3. One cycle after the 4th rising edge: pos = 1, led2 = FF, led1 = 7F, step_strobe high for exactly 1 cycle.
3. Bounce: run 7 steps from reset -> pos = 7, led8 = FF, led7 = 7F, led6 = 3F, led1 = 01. Next step -> pos = 6, led7 = FF, led8 = 7F. Direction reversal at pos 0 -> pos = 1.
4. Wrap: at pos = 7, set mode = 1 and step -> pos = 0, led1 = FF, led8 = 7F. Switching to mode = 1 while in DOWN at pos = 4 -> next pos = 5.
5. enable = 0 during 12 fclk pulses -> outputs and frame count frozen. Re-enable while fclk is high -> no tick until the next rising edge. Separately, fclk held high for 50 cycles -> exactly one tick counted.
6. reset asserted in the same cycle as a 4th-frame tick -> reset values appear and step_strobe = 0. With STEP_FRAMES = 1 and DECAY_SHIFT = 8 -> only the dot LED is non-zero after every tick.

Source files
------------

// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: scanner bus; enable/fclk/mode in, led1..led8 levels, pos and step_strobe out
interface led_pattern_seq_if;
  logic enable;
  logic fclk;
  logic mode;
  logic [7:0] led1, led2, led3, led4, led5, led6, led7, led8;
  logic [2:0] pos;
  logic step_strobe;
  modport master (
    output enable, fclk, mode,
    input  led1, led2, led3, led4, led5, led6, led7, led8, pos, step_strobe
  );
  modport slave (
    input  enable, fclk, mode,
    output led1, led2, led3, led4, led5, led6, led7, led8, pos, step_strobe
  );
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: bouncing/wrapping scanner dot with decaying tail, stepped on PWM frame ticks; ports clk, reset, bus (slave: enable, fclk, mode in; led1..led8, pos, step_strobe out)
module led_pattern_seq #(
  parameter int STEP_FRAMES = 4,
  parameter int DECAY_SHIFT = 1,
  parameter logic [7:0] PEAK = 8'hFF
) (
  input logic clk,
  input logic reset,
  led_pattern_seq_if.slave bus
);
  typedef enum logic {UP, DOWN} dir_t;
  localparam logic [7:0] LAST = 8'(STEP_FRAMES - 1);
  dir_t dir, dir_n;
  logic fclk_d, tick, adv, step, strobe;
  logic [7:0] cnt, cnt_n;
  logic [2:0] pos_q, pos_n;
  logic [7:0] lvl [8];
  logic [7:0] lvl_n [8];
  always_comb begin
    tick = bus.fclk & ~fclk_d;
    adv = tick & bus.enable;
    step = adv & (cnt == LAST);
    cnt_n = adv ? (step ? 8'd0 : cnt + 8'd1) : cnt;
    pos_n = pos_q;
    dir_n = dir;
    if (step) begin
      if (bus.mode) begin
        pos_n = pos_q + 3'd1;
        dir_n = UP;
      end else if (dir == UP) begin
        pos_n = (pos_q == 3'd7) ? 3'd6 : pos_q + 3'd1;
        dir_n = (pos_q == 3'd7) ? DOWN : UP;
      end else begin
        pos_n = (pos_q == 3'd0) ? 3'd1 : pos_q - 3'd1;
        dir_n = (pos_q == 3'd0) ? UP : DOWN;
      end
    end
    for (int i = 0; i < 8; i++)
      lvl_n[i] = !step ? lvl[i] : (3'(i) == pos_n) ? PEAK : lvl[i] >> DECAY_SHIFT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) lvl[i] <= (i == 0) ? PEAK : 8'd0;
      pos_q <= 3'd0;
      dir <= UP;
      cnt <= 8'd0;
      fclk_d <= 1'b0;
      strobe <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) lvl[i] <= lvl_n[i];
      pos_q <= pos_n;
      dir <= dir_n;
      cnt <= cnt_n;
      fclk_d <= bus.fclk;
      strobe <= step;
    end
  end
  assign bus.led1 = lvl[0];
  assign bus.led2 = lvl[1];
  assign bus.led3 = lvl[2];
  assign bus.led4 = lvl[3];
  assign bus.led5 = lvl[4];
  assign bus.led6 = lvl[5];
  assign bus.led7 = lvl[6];
  assign bus.led8 = lvl[7];
  assign bus.pos = pos_q;
  assign bus.step_strobe = strobe;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: table-driven scoreboard bench for led_pattern_seq (default and STEP_FRAMES=1/DECAY_SHIFT=8 instances)
module tb_led_pattern_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  led_pattern_seq_if a();
  led_pattern_seq_if b();
  led_pattern_seq dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  led_pattern_seq #(.STEP_FRAMES(1), .DECAY_SHIFT(8), .PEAK(8'hFF)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  typedef struct packed {logic [2:0] pos; logic [63:0] l;} exp_t;
  typedef struct packed {logic mode; logic [2:0] pos;} vec_t;
  exp_t sb[$];
  exp_t cur;
  logic [7:0] ml [8];
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [63:0] la, lb;
  assign la = {a.led8, a.led7, a.led6, a.led5, a.led4, a.led3, a.led2, a.led1};
  assign lb = {b.led8, b.led7, b.led6, b.led5, b.led4, b.led3, b.led2, b.led1};
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic [63:0] pack_ml();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[8*i +: 8] = ml[i];
    return p;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) ml[i] = (i == 0) ? 8'hFF : 8'h00;
    cur.pos = 3'd0;
    cur.l = pack_ml();
    sb.delete();
  endtask
  task automatic push_step(logic [2:0] p);
    exp_t e;
    for (int i = 0; i < 8; i++) ml[i] = ml[i] >> 1;
    ml[p] = 8'hFF;
    e.pos = p;
    e.l = pack_ml();
    sb.push_back(e);
  endtask
  task automatic frame(int hi, int lo);
    a.fclk = 1'b1;
    repeat (hi) @(negedge clk);
    a.fclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  task automatic step4(logic [2:0] p);
    repeat (3) frame(3, 5);
    push_step(p);
    frame(3, 5);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_pos", 64'(a.pos), 64'd0);
    chk("rst_leds", la, 64'h00000000000000FF);
    chk("rst_strobe", 64'(a.step_strobe), 64'd0);
    chk("rst_b_pos", 64'(b.pos), 64'd0);
    chk("rst_b_leds", lb, 64'h00000000000000FF);
    mon_en = 1'b1;
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (a.step_strobe) begin
        if (sb.size() == 0) chk("spurious_strobe", 64'(a.step_strobe), 64'd0);
        else cur = sb.pop_front();
      end
      chk("pos", 64'(a.pos), 64'(cur.pos));
      chk("leds", la, cur.l);
    end
  end
  initial begin
    vec_t tbl [37];
    logic [2:0] p2 [10];
    tbl = '{
      '{1'b0, 3'd1}, '{1'b0, 3'd2}, '{1'b0, 3'd3}, '{1'b0, 3'd4}, '{1'b0, 3'd5},
      '{1'b0, 3'd6}, '{1'b0, 3'd7}, '{1'b0, 3'd6}, '{1'b0, 3'd5}, '{1'b0, 3'd4},
      '{1'b0, 3'd3}, '{1'b0, 3'd2}, '{1'b0, 3'd1}, '{1'b0, 3'd0}, '{1'b0, 3'd1},
      '{1'b0, 3'd2}, '{1'b0, 3'd3}, '{1'b0, 3'd4}, '{1'b0, 3'd5}, '{1'b0, 3'd6},
      '{1'b0, 3'd7}, '{1'b0, 3'd6}, '{1'b0, 3'd5}, '{1'b0, 3'd4}, '{1'b1, 3'd5},
      '{1'b0, 3'd6}, '{1'b1, 3'd7}, '{1'b1, 3'd0}, '{1'b0, 3'd1}, '{1'b1, 3'd2},
      '{1'b0, 3'd3}, '{1'b0, 3'd4}, '{1'b0, 3'd5}, '{1'b0, 3'd6}, '{1'b0, 3'd7},
      '{1'b1, 3'd0}, '{1'b0, 3'd1}
    };
    p2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4};
    a.enable = 1'b1;
    a.fclk = 1'b0;
    a.mode = 1'b0;
    b.enable = 1'b1;
    b.fclk = 1'b0;
    b.mode = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 37; k++) begin
      a.mode = tbl[k].mode;
      step4(tbl[k].pos);
      if (k == 0) chk("step1_led21", 64'(la[15:0]), 64'h0000_0000_0000_FF7F);
      if (k == 6) chk("step7_all", la, 64'hFF7F3F1F0F070301);
      if (k == 7) chk("step8_led87", 64'(la[63:48]), 64'h0000_0000_0000_7FFF);
      if (k == 27) chk("wrap_led81", 64'({la[63:56], la[7:0]}), 64'h0000_0000_0000_7FFF);
    end
    a.mode = 1'b0;
    repeat (2) frame(3, 5);
    a.enable = 1'b0;
    repeat (12) frame(3, 5);
    a.fclk = 1'b1;
    repeat (2) @(negedge clk);
    a.enable = 1'b1;
    repeat (3) @(negedge clk);
    a.fclk = 1'b0;
    repeat (5) @(negedge clk);
    frame(3, 5);
    push_step(3'd2);
    frame(3, 5);
    frame(50, 5);
    repeat (2) frame(3, 5);
    push_step(3'd3);
    frame(3, 5);
    repeat (3) frame(3, 5);
    a.fclk = 1'b1;
    reset = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("coinc_strobe", 64'(a.step_strobe), 64'd0);
    chk("coinc_pos", 64'(a.pos), 64'd0);
    chk("coinc_leds", la, 64'h00000000000000FF);
    model_reset();
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    a.fclk = 1'b0;
    repeat (5) @(negedge clk);
    repeat (2) frame(3, 5);
    push_step(3'd1);
    frame(3, 5);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      b.fclk = 1'b1;
      @(negedge clk);
      chk("b_strobe", 64'(b.step_strobe), 64'd1);
      chk("b_pos", 64'(b.pos), 64'(p2[k]));
      chk("b_leds", lb, 64'hFF << (8 * p2[k]));
      b.fclk = 1'b0;
      repeat (3) @(negedge clk);
      chk("b_strobe_low", 64'(b.step_strobe), 64'd0);
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
